// File: rtl/bus_slave_rx.sv
// Slave endpoint of the 24-bit valid/ready bus: frames are staged in a FIFO and released to the
// reader only after their checksum verifies. Optional SEQ tracking: define BUS_RX_SEQ_CHECK_EN.
module bus_slave_rx #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             bus_valid,
  input  logic [23:0]      bus_data,
  output logic             slave_ready,
  input  logic             rd_en,
  output logic [23:0]      rd_data,
  output logic             rd_vld,
  output logic             rd_empty,
  output logic             frame_ok,
  output logic             frame_err,
`ifdef BUS_RX_SEQ_CHECK_EN
  output logic             seq_err,
`endif
  output logic [CNT_W-1:0] ok_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {HUNT, PAYLOAD, DROP, CHECK} state_t;

  localparam logic [AW:0]      FULL_FILL = (AW+1)'(DEPTH);
  localparam logic [AW:0]      PTR_ONE   = (AW+1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t      state, state_nxt;
  logic [23:0] mem [DEPTH];
  logic [AW:0] wr_ptr, cm_ptr, rd_ptr;
  logic [23:0] sum;
  logic [7:0]  remaining;
  logic [7:0]  hdr_len;
  logic        hdr_valid, len_fits, accept, pop;
  logic        load_frame, count, wr_en, commit, rollback, ok_pulse, err_pulse;

  assign hdr_len   = bus_data[15:8];
  assign hdr_valid = (bus_data[23:16] == 8'hA5) && (hdr_len != 8'd0);
  assign len_fits  = int'(hdr_len) <= DEPTH;
  assign rd_empty  = (cm_ptr == rd_ptr);
  assign accept    = bus_valid && slave_ready;
  assign pop       = rd_en && !rd_empty;

  // The checksum and dropped words need no storage, so those phases never back-pressure.
  always_comb begin
    slave_ready = (wr_ptr - rd_ptr) != FULL_FILL;
    if (state == DROP || state == CHECK) slave_ready = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (RST) state <= HUNT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load_frame = 1'b0;
    count      = 1'b0;
    wr_en      = 1'b0;
    commit     = 1'b0;
    rollback   = 1'b0;
    ok_pulse   = 1'b0;
    err_pulse  = 1'b0;
    case (state)
      HUNT: begin
        if (accept && hdr_valid) begin
          load_frame = 1'b1;
          state_nxt  = len_fits ? PAYLOAD : DROP;
        end
      end
      PAYLOAD: begin
        if (accept) begin
          wr_en = 1'b1;
          count = 1'b1;
          if (remaining == 8'd1) state_nxt = CHECK;
        end
      end
      DROP: begin
        if (accept) begin
          count = 1'b1;
          if (remaining == 8'd1) begin
            err_pulse = 1'b1;
            state_nxt = HUNT;
          end
        end
      end
      CHECK: begin
        if (accept) begin
          if (bus_data == sum) begin
            commit   = 1'b1;
            ok_pulse = 1'b1;
          end else begin
            rollback  = 1'b1;
            err_pulse = 1'b1;
          end
          state_nxt = HUNT;
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= bus_data;
  end

  // A rejected frame rewinds the speculative pointer; a good one publishes it to the reader.
  always_ff @(posedge clk) begin
    if (RST) begin
      wr_ptr    <= '0;
      cm_ptr    <= '0;
      rd_ptr    <= '0;
      sum       <= '0;
      remaining <= '0;
      ok_cnt    <= '0;
      err_cnt   <= '0;
      rd_data   <= '0;
      rd_vld    <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (load_frame) begin
        remaining <= hdr_len;
        sum       <= '0;
      end else if (count) begin
        remaining <= remaining - 8'd1;
      end
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
        sum    <= sum + bus_data;
      end
      if (rollback) wr_ptr <= cm_ptr;
      if (commit)   cm_ptr <= wr_ptr;
      frame_ok  <= ok_pulse;
      frame_err <= err_pulse;
      if (ok_pulse && ok_cnt != '1)   ok_cnt  <= ok_cnt + CNT_ONE;
      if (err_pulse && err_cnt != '1) err_cnt <= err_cnt + CNT_ONE;
      rd_vld <= pop;
      if (pop) begin
        rd_data <= mem[rd_ptr[AW-1:0]];
        rd_ptr  <= rd_ptr + PTR_ONE;
      end
    end
  end

`ifdef BUS_RX_SEQ_CHECK_EN
  logic [7:0] exp_seq;

  // Only headers that open a stored frame take part in sequence tracking.
  always_ff @(posedge clk) begin
    if (RST) begin
      exp_seq <= '0;
      seq_err <= 1'b0;
    end else begin
      seq_err <= 1'b0;
      if (load_frame && len_fits) begin
        seq_err <= (bus_data[7:0] != exp_seq);
        exp_seq <= bus_data[7:0] + 8'd1;
      end
    end
  end
`endif

endmodule
